// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache. Serves 32-bit words to fetch.
// On a miss it refills a whole 128-bit line from RAM port A.
// state | meaning
// IDLE  | accepting requests; a hit answers on the next cycle
// FILL  | mem_addr is held on the missing line until the RAM wait count runs out
module inst_cache #(
  parameter int ADDR_WIDTH   = 17,
  parameter int INDEX_WIDTH  = 4,
  parameter int MISS_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic [31:0]           req_pc,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [31:0]           resp_inst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [127:0]          mem_data
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int CNT_WIDTH = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MISS_LATENCY - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                 state;
  logic [LINES-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]   tag_q  [LINES];
  logic [127:0]           data_q [LINES];
  logic [CNT_WIDTH-1:0]   wait_cnt;
  logic [1:0]             fill_word;

  logic [1:0]             req_word;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] fill_index;
  logic [TAG_WIDTH-1:0]   fill_tag;
  logic                   hit;
  logic                   fill_done;
  logic [31:0]            hit_inst;
  logic [31:0]            fill_inst;
  logic                   unused_pc_bits;

  // Byte offset and bits above the RAM window alias onto the same line.
  assign unused_pc_bits = ^{req_pc[1:0], req_pc[31:ADDR_WIDTH+4]};

  assign req_word   = req_pc[3:2];
  assign req_index  = req_pc[INDEX_WIDTH+3:4];
  assign req_tag    = req_pc[ADDR_WIDTH+3:INDEX_WIDTH+4];
  // The held line address already carries the index and tag of the refill.
  assign fill_index = mem_addr[INDEX_WIDTH-1:0];
  assign fill_tag   = mem_addr[ADDR_WIDTH-1:INDEX_WIDTH];

  assign hit       = valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign hit_inst  = data_q[req_index][{req_word, 5'b0} +: 32];
  assign fill_inst = mem_data[{fill_word, 5'b0} +: 32];
  assign fill_done = (state == FILL) && (wait_cnt == CNT_LAST);

  assign req_ready = (state == IDLE) && !flush;

  // Line storage: only valid bits are cleared, so tags/data need no reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush && fill_done) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= mem_data;
    end
  end

  // Control FSM with registered response, RAM address and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid_q    <= '0;
      resp_valid <= 1'b0;
      resp_inst  <= '0;
      mem_addr   <= '0;
      wait_cnt   <= '0;
      fill_word  <= '0;
    end else if (flush) begin
      // An in-flight refill is dropped without writing the line.
      state      <= IDLE;
      valid_q    <= '0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid && req_ready) begin
            if (hit) begin
              resp_valid <= 1'b1;
              resp_inst  <= hit_inst;
            end else begin
              state     <= FILL;
              mem_addr  <= req_pc[ADDR_WIDTH+3:4];
              wait_cnt  <= '0;
              fill_word <= req_word;
            end
          end
        end
        FILL: begin
          if (fill_done) begin
            state               <= IDLE;
            valid_q[fill_index] <= 1'b1;
            resp_valid          <= 1'b1;
            resp_inst           <= fill_inst;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Bench for inst_cache: directed vector table, hand-written corner sequences,
// and randomized traffic against a line-address-level reference model.
module tb_inst_cache;

  localparam int LAT = 2;

  logic         clk;
  logic         rst, flush, req_valid;
  logic [31:0]  req_pc;
  logic         req_ready, resp_valid;
  logic [31:0]  resp_inst;
  logic [16:0]  mem_addr;
  logic [127:0] mem_data;

  logic         rst1, flush1, req_valid1;
  logic [31:0]  req_pc1;
  logic         req_ready1, resp_valid1;
  logic [31:0]  resp_inst1;
  logic [16:0]  mem_addr1;
  logic [127:0] mem_data1;

  int checks = 0;
  int failures = 0;
  logic ready_s;

  // RAM contents: line 0x10 holds 1111..,2222..,3333..,4444..; others hashed
  function automatic logic [31:0] ram_word(input logic [16:0] la, input int w);
    if (la == 17'h10) return 32'h1111_1111 * (w + 1);
    return (32'(la) * 32'h9E37_79B1) ^ (32'(w) << 28) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] ram_line(input logic [16:0] la);
    return {ram_word(la, 3), ram_word(la, 2), ram_word(la, 1), ram_word(la, 0)};
  endfunction

  assign mem_data  = ram_line(mem_addr);
  assign mem_data1 = ram_line(mem_addr1);

  inst_cache #(.ADDR_WIDTH(17), .INDEX_WIDTH(4), .MISS_LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_pc(req_pc),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_inst(resp_inst),
    .mem_addr(mem_addr), .mem_data(mem_data));

  inst_cache #(.ADDR_WIDTH(17), .INDEX_WIDTH(4), .MISS_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst1), .flush(flush1), .req_valid(req_valid1), .req_pc(req_pc1),
    .req_ready(req_ready1), .resp_valid(resp_valid1), .resp_inst(resp_inst1),
    .mem_addr(mem_addr1), .mem_data(mem_data1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle: inputs at negedge, ready sampled before the edge,
  // registered outputs sampled 1 time unit after the edge.
  task automatic tick(input logic r, input logic f, input logic v, input logic [31:0] pc);
    @(negedge clk);
    rst = r; flush = f; req_valid = v; req_pc = pc;
    #1 ready_s = req_ready;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (cache as a set of line addresses) ----
  bit          m_valid [16];
  logic [16:0] m_line  [16];
  int          m_busy;
  logic [16:0] m_pend_line;
  logic [31:0] m_pend_inst;
  logic        m_ready, m_rv;
  logic [31:0] m_inst;
  logic [16:0] m_addr;

  task automatic model_step(input logic r, input logic f, input logic v, input logic [31:0] pc);
    logic [16:0] la;
    int idx;
    la  = pc[20:4];
    idx = int'(la[3:0]);
    m_ready = (m_busy == 0) && !f;
    if (r) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_busy = 0; m_rv = 0; m_inst = 0; m_addr = 0;
    end else if (f) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_busy = 0; m_rv = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      m_rv = 0;
      if (m_busy == 0) begin
        m_valid[int'(m_pend_line[3:0])] = 1;
        m_line[int'(m_pend_line[3:0])]  = m_pend_line;
        m_rv = 1;
        m_inst = m_pend_inst;
      end
    end else begin
      m_rv = 0;
      if (v) begin
        if (m_valid[idx] && m_line[idx] == la) begin
          m_rv = 1;
          m_inst = ram_word(la, int'(pc[3:2]));
        end else begin
          m_busy = LAT;
          m_addr = la;
          m_pend_line = la;
          m_pend_inst = ram_word(la, int'(pc[3:2]));
        end
      end
    end
  endtask

  typedef struct {
    logic        f;
    logic        v;
    logic [31:0] pc;
    logic        exp_ready;
    logic        exp_rv;
    logic [31:0] exp_inst;
    logic [16:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic f, input logic v, input logic [31:0] pc,
                              input logic rdy, input logic rv, input logic [31:0] inst,
                              input logic [16:0] addr);
    vec_t t;
    t.f = f; t.v = v; t.pc = pc; t.exp_ready = rdy; t.exp_rv = rv;
    t.exp_inst = inst; t.exp_addr = addr;
    vecs.push_back(t);
  endfunction

  initial begin
    logic [31:0] x;
    logic [31:0] rnd;
    logic [16:0] la;
    logic r, f, v;

    rst = 1; flush = 0; req_valid = 0; req_pc = 0;
    rst1 = 1; flush1 = 0; req_valid1 = 0; req_pc1 = 0;
    x = ram_word(17'h20, 1);

    //   flush v  pc           rdy rv inst          addr
    add(0, 1, 32'h104, 1, 0, 32'h0,          17'h10);
    add(0, 0, 32'h0,   0, 0, 32'h0,          17'h10);
    add(0, 0, 32'h0,   0, 1, 32'h2222_2222,  17'h10);
    add(0, 1, 32'h100, 1, 1, 32'h1111_1111,  17'h10);
    add(0, 1, 32'h108, 1, 1, 32'h3333_3333,  17'h10);
    add(0, 1, 32'h10C, 1, 1, 32'h4444_4444,  17'h10);
    add(0, 0, 32'h0,   1, 0, 32'h4444_4444,  17'h10);
    add(0, 1, 32'h204, 1, 0, 32'h4444_4444,  17'h20);
    add(0, 0, 32'h0,   0, 0, 32'h4444_4444,  17'h20);
    add(0, 0, 32'h0,   0, 1, x,              17'h20);
    add(0, 1, 32'h104, 1, 0, x,              17'h10);
    add(0, 0, 32'h0,   0, 0, x,              17'h10);
    add(0, 0, 32'h0,   0, 1, 32'h2222_2222,  17'h10);
    add(0, 1, 32'h204, 1, 0, 32'h2222_2222,  17'h20);
    add(0, 0, 32'h0,   0, 0, 32'h2222_2222,  17'h20);
    add(1, 0, 32'h0,   0, 0, 32'h2222_2222,  17'h20);
    add(0, 1, 32'h104, 1, 0, 32'h2222_2222,  17'h10);
    add(0, 0, 32'h0,   0, 0, 32'h2222_2222,  17'h10);
    add(0, 0, 32'h0,   0, 1, 32'h2222_2222,  17'h10);
    add(0, 1, 32'h10C, 1, 1, 32'h4444_4444,  17'h10);
    add(1, 1, 32'h104, 0, 0, 32'h4444_4444,  17'h10);
    add(0, 1, 32'h104, 1, 0, 32'h4444_4444,  17'h10);
    add(0, 0, 32'h0,   0, 0, 32'h4444_4444,  17'h10);
    add(0, 0, 32'h0,   0, 1, 32'h2222_2222,  17'h10);

    // reset state
    tick(1, 0, 0, 0);
    chk("reset_resp_valid", 32'(resp_valid), 32'h0);
    chk("reset_resp_inst", resp_inst, 32'h0);
    chk("reset_mem_addr", 32'(mem_addr), 32'h0);

    // table: miss, hits, conflict, flush mid-fill, flush after hit
    foreach (vecs[i]) begin
      tick(0, vecs[i].f, vecs[i].v, vecs[i].pc);
      chk($sformatf("vec%0d_ready", i), 32'(ready_s), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_resp_valid", i), 32'(resp_valid), 32'(vecs[i].exp_rv));
      chk($sformatf("vec%0d_resp_inst", i), resp_inst, vecs[i].exp_inst);
      chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
    end

    // reset in the middle of a refill; line 0x10 was cached before
    tick(0, 0, 1, 32'h204);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("rstfill_resp_valid", 32'(resp_valid), 32'h0);
    chk("rstfill_mem_addr", 32'(mem_addr), 32'h0);
    tick(0, 0, 1, 32'h104);
    chk("rstfill_ready", 32'(ready_s), 32'h1);
    chk("rstfill_remiss_valid", 32'(resp_valid), 32'h0);
    chk("rstfill_remiss_addr", 32'(mem_addr), 32'h10);
    tick(0, 0, 0, 0);
    chk("rstfill_wait_valid", 32'(resp_valid), 32'h0);
    tick(0, 0, 0, 0);
    chk("rstfill_resp_valid2", 32'(resp_valid), 32'h1);
    chk("rstfill_resp_inst", resp_inst, 32'h2222_2222);

    // randomized traffic against the model
    model_step(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom % 300) == 0;
      f   = ($urandom % 30) == 0;
      v   = ($urandom % 4) != 0;
      rnd = $urandom;
      la  = {13'($urandom_range(0, 2)), 4'($urandom_range(0, 3))};
      model_step(r, f, v, {rnd[31:21], la, rnd[3:0]});
      tick(r, f, v, {rnd[31:21], la, rnd[3:0]});
      chk("rnd_ready", 32'(ready_s), 32'(m_ready));
      chk("rnd_resp_valid", 32'(resp_valid), 32'(m_rv));
      chk("rnd_resp_inst", resp_inst, m_inst);
      chk("rnd_mem_addr", 32'(mem_addr), 32'(m_addr));
    end

    // single-cycle RAM build: miss answers at accept+2, byte offset ignored
    @(negedge clk);
    rst1 = 0; req_valid1 = 1; req_pc1 = 32'h104;
    #1 chk("lat1_ready", 32'(req_ready1), 32'h1);
    @(posedge clk); #1;
    chk("lat1_miss_valid", 32'(resp_valid1), 32'h0);
    chk("lat1_mem_addr", 32'(mem_addr1), 32'h10);
    @(negedge clk);
    req_valid1 = 0;
    #1 chk("lat1_fill_ready", 32'(req_ready1), 32'h0);
    @(posedge clk); #1;
    chk("lat1_resp_valid", 32'(resp_valid1), 32'h1);
    chk("lat1_resp_inst", resp_inst1, 32'h2222_2222);
    @(negedge clk);
    req_valid1 = 1; req_pc1 = 32'h106;
    @(posedge clk); #1;
    chk("lat1_alias_valid", 32'(resp_valid1), 32'h1);
    chk("lat1_alias_inst", resp_inst1, 32'h2222_2222);
    @(negedge clk);
    req_valid1 = 0;
    @(posedge clk); #1;
    chk("lat1_idle_valid", 32'(resp_valid1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
